// File: rtl/comp_pkg.sv
// comp_pkg: shared defaults and FSM state encoding for the comparator arbiter
package comp_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/comp_arbiter_if.sv
// comp_arbiter_if: two requester operand handshakes plus the shared result handshake
interface comp_arbiter_if import comp_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             resp_valid, resp_ready, resp_id, resp_l, resp_g, resp_e;
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_l, resp_g, resp_e
  );
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_l, resp_g, resp_e
  );
endinterface

// File: rtl/comp4b.sv
// comp4b: unsigned magnitude comparator producing less/greater/equal flags
module comp4b import comp_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             l,
  output logic             g,
  output logic             e
);
  assign l = a < b;
  assign g = a > b;
  assign e = a == b;
endmodule

// File: rtl/comp_arbiter.sv
// comp_arbiter: round-robin arbiter feeding one shared comparator with a held, counted response
module comp_arbiter import comp_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  comp_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] done_cnt
);
  state_t state, state_nx;
  logic last, gnt1, accept, hs, cap_id, cl, cg, ce;
  logic [WIDTH-1:0] cap_a, cap_b;
  comp4b #(.WIDTH(WIDTH)) u_cmp (.a(cap_a), .b(cap_b), .l(cl), .g(cg), .e(ce));
  always_comb gnt1 = bus.req1_valid && (!bus.req0_valid || !last);
  always_comb begin
    bus.req0_ready = !rst && state == IDLE && bus.req0_valid && !gnt1;
    bus.req1_ready = !rst && state == IDLE && gnt1;
    bus.resp_valid = state == HOLD;
  end
  always_comb begin
    accept   = bus.req0_ready || bus.req1_ready;
    hs       = bus.resp_valid && bus.resp_ready;
    state_nx = state == IDLE ? (accept ? CMP : IDLE) : state == CMP ? HOLD : (hs ? IDLE : HOLD);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      last         <= 1'b1;
      done_cnt     <= '0;
      cap_a        <= '0;
      cap_b        <= '0;
      cap_id       <= 1'b0;
      bus.resp_id  <= 1'b0;
      bus.resp_l   <= 1'b0;
      bus.resp_g   <= 1'b0;
      bus.resp_e   <= 1'b0;
    end else begin
      if (accept) begin
        cap_a  <= gnt1 ? bus.req1_a : bus.req0_a;
        cap_b  <= gnt1 ? bus.req1_b : bus.req0_b;
        cap_id <= gnt1;
      end
      if (state == CMP) begin
        bus.resp_id <= cap_id;
        bus.resp_l  <= cl;
        bus.resp_g  <= cg;
        bus.resp_e  <= ce;
      end
      if (hs) begin
        last <= bus.resp_id;
        if (!(&done_cnt)) done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_comp_arbiter.sv
// tb_comp_arbiter: directed self-checking bench for comp_arbiter
module tb_comp_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] done_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  comp_arbiter_if #(.WIDTH(4)) bus();
  comp_arbiter dut (.clk(clk), .rst(rst), .bus(bus), .done_cnt(done_cnt));
  always #5 clk = ~clk;
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = 4'd0;
    bus.req0_b = 4'd0;
    bus.req1_a = 4'd0;
    bus.req1_b = 4'd0;
    bus.resp_ready = 1'b0;
  endtask
  task automatic do_reset;
    clear_in();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    clear_in();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    nxt();
    nxt();
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    n_cmp++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_resp: got %b want 00000", {bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e});
    end
    n_cmp++;
    if (done_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %0d want 0", done_cnt);
    end
    clear_in();
    rst = 1'b0;
    nxt();
  endtask
  task automatic test_basic;
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'd1;
    bus.req0_b = 4'd2;
    bus.resp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL basic_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    nxt();
    bus.req0_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_cyc1_valid: got %b want 0", bus.resp_valid);
    end
    nxt();
    #1;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e} !== 5'b10100) begin
      n_bad++;
      $display("FAIL basic_resp: got %b want 10100", {bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e});
    end
    nxt();
    #1;
    n_cmp++;
    if ({bus.resp_valid, done_cnt} !== {1'b0, 8'd1}) begin
      n_bad++;
      $display("FAIL basic_done: got valid=%b cnt=%0d want valid=0 cnt=1", bus.resp_valid, done_cnt);
    end
  endtask
  task automatic test_round_robin;
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'd5;
    bus.req0_b = 4'd3;
    bus.req1_valid = 1'b1;
    bus.req1_a = 4'd4;
    bus.req1_b = 4'd4;
    bus.resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [1:0] er;
      logic [4:0] ep;
      er = (t % 2 == 1) ? 2'b01 : 2'b10;
      ep = (t % 2 == 1) ? 5'b11001 : 5'b10010;
      #1;
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready} !== er) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %b want %b", t, {bus.req0_ready, bus.req1_ready}, er);
      end
      nxt();
      #1;
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready, bus.resp_valid} !== 3'b000) begin
        n_bad++;
        $display("FAIL rr_cmp%0d: got %b want 000", t, {bus.req0_ready, bus.req1_ready, bus.resp_valid});
      end
      nxt();
      #1;
      n_cmp++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e} !== ep) begin
        n_bad++;
        $display("FAIL rr_resp%0d: got %b want %b", t, {bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e}, ep);
      end
      nxt();
    end
    #1;
    n_cmp++;
    if (done_cnt !== 8'd4) begin
      n_bad++;
      $display("FAIL rr_cnt: got %0d want 4", done_cnt);
    end
    clear_in();
  endtask
  task automatic test_hold;
    bus.req1_valid = 1'b1;
    bus.req1_a = 4'd8;
    bus.req1_b = 4'd5;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL hold_grant: got %b want 01", {bus.req0_ready, bus.req1_ready});
    end
    nxt();
    bus.req0_valid = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL hold_cmp_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    for (int k = 0; k < 5; k++) begin
      nxt();
      #1;
      n_cmp++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e, bus.req0_ready, bus.req1_ready} !== 7'b1101000 || done_cnt !== 8'd4) begin
        n_bad++;
        $display("FAIL hold_stable%0d: got %b cnt=%0d want 1101000 cnt=4", k,
                 {bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e, bus.req0_ready, bus.req1_ready}, done_cnt);
      end
    end
    nxt();
    clear_in();
    bus.resp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_g} !== 2'b11 || done_cnt !== 8'd4) begin
      n_bad++;
      $display("FAIL hold_pre_hs: got valid,g=%b cnt=%0d want 11 cnt=4", {bus.resp_valid, bus.resp_g}, done_cnt);
    end
    nxt();
    #1;
    n_cmp++;
    if ({bus.resp_valid, done_cnt} !== {1'b0, 8'd5}) begin
      n_bad++;
      $display("FAIL hold_done: got valid=%b cnt=%0d want valid=0 cnt=5", bus.resp_valid, done_cnt);
    end
    clear_in();
  endtask
  task automatic test_reset_mid;
    do_reset();
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'd7;
    bus.req0_b = 4'd7;
    nxt();
    bus.req0_valid = 1'b0;
    nxt();
    nxt();
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'd2;
    bus.req0_b = 4'd10;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10 || done_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL rmid_grant: got %b cnt=%0d want 10 cnt=1", {bus.req0_ready, bus.req1_ready}, done_cnt);
    end
    nxt();
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e} !== 5'b00000 || done_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL rmid_after: got %b cnt=%0d want 00000 cnt=0", {bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e}, done_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      nxt();
      #1;
      n_cmp++;
      if (bus.resp_valid !== 1'b0 || done_cnt !== 8'd0) begin
        n_bad++;
        $display("FAIL rmid_never%0d: got valid=%b cnt=%0d want valid=0 cnt=0", k, bus.resp_valid, done_cnt);
      end
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL rmid_tie: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    nxt();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    nxt();
    nxt();
  endtask
  task automatic test_capture;
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'd1;
    bus.req0_b = 4'd1;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL cap_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    nxt();
    bus.req0_valid = 1'b0;
    bus.req0_a = 4'd9;
    bus.req0_b = 4'd2;
    nxt();
    #1;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e} !== 5'b10001) begin
      n_bad++;
      $display("FAIL cap_resp: got %b want 10001", {bus.resp_valid, bus.resp_id, bus.resp_l, bus.resp_g, bus.resp_e});
    end
    nxt();
    clear_in();
  endtask
  task automatic test_saturate;
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_a = 4'd3;
    bus.req0_b = 4'd7;
    bus.resp_ready = 1'b1;
    repeat (255 * 3) nxt();
    #1;
    n_cmp++;
    if (done_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_255: got %0d want 255", done_cnt);
    end
    repeat (5 * 3) nxt();
    #1;
    n_cmp++;
    if (done_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_260: got %0d want 255", done_cnt);
    end
    clear_in();
  endtask
  initial begin
    clear_in();
    test_reset();
    test_basic();
    test_round_robin();
    test_hold();
    test_reset_mid();
    test_capture();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/comp_arbiter.md
COMP_ARBITER -- requirements
Module: comp_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, completed-comparison counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have ports req0_valid, req1_valid, input, 1 each, requester n has an operand pair pending.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH each, operand pairs.
REQ-007 SHALL have ports req0_ready, req1_ready, output, 1 each, operand pair accepted this cycle.
REQ-008 SHALL have port resp_valid, output, 1, result pending.
REQ-009 SHALL have port resp_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port resp_id, output, 1, requester index that owns the result.
REQ-011 SHALL have ports resp_l, resp_g, resp_e, output, 1 each, A<B, A>B, A==B (unsigned).
REQ-012 SHALL have port done_cnt, output, CNT_W, count of completed responses.

Function
REQ-013 SHALL implement FSM with states IDLE, CMP, HOLD.
REQ-014 SHALL, in IDLE with at least one reqN_valid, assert exactly one reqN_ready combinationally for the granted requester, capture its a/b and id, and move to CMP.
REQ-015 SHALL grant the only valid requester when one is valid; when both are valid, grant the requester not granted last (round-robin).
REQ-016 SHALL initialise last-grant pointer to 1 at reset so requester 0 wins the first tie.
REQ-017 SHALL keep reqN_ready low in CMP and HOLD and in IDLE when no request is valid.
REQ-018 SHALL, in CMP, apply captured operands to the comparator, register l/g/e and id into result registers, and move to HOLD.
REQ-019 SHALL hold resp_valid high in HOLD with stable resp_id/l/g/e until resp_valid&&resp_ready.
REQ-020 SHALL, on the response handshake, increment done_cnt, update last-grant to resp_id, and return to IDLE.
REQ-021 SHALL saturate done_cnt at all-ones; no wrap to zero.
REQ-022 SHALL produce exactly one of resp_l/resp_g/resp_e high whenever resp_valid is high.
REQ-023 SHALL give latency: request accepted in cycle N -> resp_valid first high in cycle N+2; earliest next accept in the cycle after response handshake.
REQ-024 SHALL ignore resp_ready outside HOLD and ignore operand changes after capture.

Reset
REQ-025 SHALL, with rst high at a clock edge, force state IDLE, last-grant 1, done_cnt 0, resp_valid 0, resp_id/l/g/e 0.
REQ-026 SHALL drive req0_ready and req1_ready low while rst is high.
REQ-027 SHALL abort any in-flight comparison on reset mid-operation; the aborted result is never presented and not counted.

Structure
REQ-028 SHALL place WIDTH default, CNT_W default and FSM state encoding in shared package comp_pkg.
REQ-029 SHALL instantiate the existing comp4b comparator as its single sub-module for the l/g/e computation.

Verification
REQ-030 SHALL cover: req0 only, A=1 B=2, resp_ready=1 -> req0_ready in cycle 0, resp_valid cycle 2, id=0, l=1 g=0 e=0, done_cnt=1.
REQ-031 SHALL cover: both valid every cycle, req0 A=5 B=3, req1 A=4 B=4 -> grants alternate 0,1,0,1; responses g=1 for id 0, e=1 for id 1.
REQ-032 SHALL cover: req1 A=8 B=5, resp_ready held low 5 cycles -> resp_valid and g=1 stable throughout, no ready asserted, done_cnt unchanged until handshake.
REQ-033 SHALL cover: rst asserted in CMP after accepting A=2 B=10 -> next cycle resp_valid=0, done_cnt=0, state IDLE, first tie then grants req0.
REQ-034 SHALL cover: 260 back-to-back requests with CNT_W=8 -> done_cnt stops at 255.
REQ-035 SHALL cover: operands changed on req0 lines after ready -> response reflects captured values (A=1 B=1 -> e=1).
